// File: rtl/dsp_sub_i8_i8_i8.sv
// Signed 8-bit subtractor y = a - b (modulo 2^8), built like a DSP ALU in Z - X mode.
// Define DSP_SUB_PREG_EN to enable the P register (1-cycle latency, sync reset clears y).
module dsp_sub_i8_i8_i8 #(
  parameter int WIDTH = 8,
  parameter int ACC_W = 48
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  logic [ACC_W-1:0]       a_ext;
  logic [ACC_W-1:0]       b_ext;
  logic [ACC_W-1:0]       p;
  logic [ACC_W-WIDTH-1:0] p_hi_unused;
  logic [WIDTH-1:0]       y_d;

  always_comb begin
    a_ext = {{(ACC_W-WIDTH){a[WIDTH-1]}}, a};
    b_ext = {{(ACC_W-WIDTH){b[WIDTH-1]}}, b};
    // Z - X computed as Z + ~X with carry-in 1, the way the ALU subtracts.
    p = a_ext + ~b_ext + {{(ACC_W-1){1'b0}}, 1'b1};
    {p_hi_unused, y_d} = p;
  end

`ifdef DSP_SUB_PREG_EN
  logic [WIDTH-1:0] y_q;

  // NOTE: state is updated with non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) y_q <= '0;
    else       y_q <= y_d;
  end

  assign y = y_q;
`else
  // Ports kept so both builds share one port list; they drive nothing here.
  logic ctrl_unused;
  assign ctrl_unused = clock ^ reset;
  assign y = y_d;
`endif

endmodule

// File: tb/tb_dsp_sub_i8_i8_i8.sv
// Self-checking bench for dsp_sub_i8_i8_i8: directed literal cases plus randomized
// operands compared every cycle against an integer-arithmetic reference.
module tb_dsp_sub_i8_i8_i8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] a = 8'd0;
  logic [7:0] b = 8'd0;
  logic [7:0] y;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  dsp_sub_i8_i8_i8 dut (
    .clock(clock),
    .reset(reset),
    .a    (a),
    .b    (b),
    .y    (y)
  );

  always #5 clock = ~clock;

  // Reference: plain signed integer subtraction, keep the low byte.
  function automatic logic [7:0] model(input logic [7:0] x, input logic [7:0] z);
    int d;
    d = int'($signed(x)) - int'($signed(z));
    return d[7:0];
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: y=%h expected %h (a=%h b=%h reset=%b t=%0t)",
               name, act, exp, a, b, reset, $time);
    end
  endtask

  // Apply one operand pair between edges and check it after the design's latency.
  task automatic apply_check(input string name, input logic [7:0] va, input logic [7:0] vb,
                             input logic [7:0] exp);
    @(posedge clock);
    #2;
    a = va;
    b = vb;
`ifdef DSP_SUB_PREG_EN
    @(posedge clock);
`endif
    #1;
    check(name, y, exp);
  endtask

`ifdef DSP_SUB_PREG_EN
  logic [7:0] exp_q = 8'h00;
  always @(posedge clock) exp_q <= reset ? 8'h00 : model(a, b);
`endif

  always @(negedge clock) begin
    if (cmp_en) begin
`ifdef DSP_SUB_PREG_EN
      check("rand_preg", y, exp_q);
`else
      check("rand_comb", y, model(a, b));
`endif
    end
  end

  initial begin
    // Reset held with a=8, b=33.
    reset = 1'b1;
    a = 8'd8;
    b = 8'd33;
    repeat (2) @(posedge clock);
    #1;
`ifdef DSP_SUB_PREG_EN
    check("reset_clears", y, 8'h00);
`else
    check("reset_passthru", y, 8'hE7);
`endif
    #1;
    reset = 1'b0;
`ifdef DSP_SUB_PREG_EN
    @(posedge clock);
`endif
    #1;
    check("first_after_reset", y, 8'hE7);  // 8 - 33 = -25

    apply_check("zero",       8'h00, 8'h00, 8'h00);
    apply_check("100_m_25",   8'd100, 8'd25, 8'h4B);
    apply_check("wrap_pos",   8'h7F, 8'hFF, 8'h80);  // 127 - (-1)
    apply_check("wrap_neg",   8'h80, 8'h01, 8'h7F);  // -128 - 1
    apply_check("neg_ops",    8'hCE, 8'hEC, 8'hE2);  // -50 - (-20)
    apply_check("m1_m1",      8'hFF, 8'hFF, 8'h00);
    apply_check("min_m_max",  8'h80, 8'h7F, 8'h01);  // -128 - 127

`ifdef DSP_SUB_PREG_EN
    // Result one edge after presentation, then reset discards it.
    apply_check("preg_latency", 8'd8, 8'd33, 8'hE7);
    @(posedge clock);
    #2;
    a = 8'd10;
    b = 8'd3;
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("preg_reset_mid", y, 8'h00);
    #1;
    reset = 1'b0;
`else
    // Combinational with reset high and no clock edge between changes.
    @(posedge clock);
    #2;
    reset = 1'b1;
    a = 8'd10;
    b = 8'd3;
    #1;
    check("comb_rst_7", y, 8'h07);
    b = 8'd12;
    #1;
    check("comb_rst_m2", y, 8'hFE);
    reset = 1'b0;
`endif

    // Randomized stream; reset pulses occasionally.
    @(posedge clock);
    #2;
    cmp_en = 1'b1;
    for (int i = 0; i < 400; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      reset = ($urandom_range(0, 15) == 0);
      @(posedge clock);
      #2;
    end
    cmp_en = 1'b0;
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dsp_sub_i8_i8_i8.md
Name: dsp_sub_i8_i8_i8

Overview:
- Signed 8-bit subtractor, y = a - b, modelled as a DSP-slice ALU in subtract mode.
- Leaf arithmetic primitive used by generated datapaths and their CI self-checking benches.
- Default build is combinational (zero latency); an optional compile-time output register is available.

Parameters:
- WIDTH, 8, operand and result width. Fixed at 8 for this primitive; other values are unsupported.
- ACC_W, 48, internal DSP ALU width. Operands are sign-extended to this width.

Ports:
- clock  input  1  system clock; used only when the optional register is compiled in.
- reset  input  1  synchronous, active-high; clears the optional output register.
- a      input  8  minuend, two's complement.
- b      input  8  subtrahend, two's complement.
- y      output 8  difference a - b, two's complement, low 8 bits.

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clock.
- Datapath: sign-extend a and b to ACC_W bits. Compute P = A - B in the ALU (Z - X form, with carry-in handling inverted-operand subtraction). y = P[7:0].
- Arithmetic is modulo 2^8, with wrap-around and no saturation.
  - 127 - (-1) = -128 (0x80).
  - -128 - 1 = 127 (0x7F).
  - No overflow flag is produced.
- Default latency is 0: y is purely combinational from a and b.
  - No clock dependence.
  - reset has no effect on y; during reset y still equals a - b.
  - y is valid in the same cycle the inputs are applied, including the first cycle after reset deasserts.
- X/Z on an input propagates to y. There is no internal masking.
- No handshake; the block accepts a new operand pair every cycle.
- Upper ALU bits P[47:8] are unused and are not exported.

Optional Feature:
- Macro: DSP_SUB_PREG_EN.
- When defined, a P register is enabled: y is registered at posedge clock.
  - Latency is 1 cycle.
  - reset=1 at a clock edge forces y to 0.
  - The first valid result appears one cycle after inputs are presented with reset low.
  - Reset asserted mid-stream discards the in-flight result.
- When undefined (default), the path is combinational as described under Behaviour.
  - The clock and reset ports remain present but unused, so the port list is identical in both builds.

Test Plan:
- Hold reset for 1+ cycles with a=8, b=33. On the first cycle after reset deasserts, require y = -25 (0xE7).
- a=0, b=0 -> y=0. a=100, b=25 -> y=75 (0x4B).
- Wrap cases:
  - a=127, b=-1 -> y=-128 (0x80).
  - a=-128, b=1 -> y=127 (0x7F).
- Negative operands: a=-50, b=-20 -> y=-30 (0xE2). a=-1, b=-1 -> y=0.
- Combinational check (default build): with reset held high, a=10, b=3 -> y=7 in the same cycle. Change b to 12 -> y=-2 (0xFE) without any clock edge.
- DSP_SUB_PREG_EN build:
  - a=8, b=33 applied with reset low -> y=-25 exactly one edge later.
  - Assert reset -> y=0 at the next edge.
